// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg: shared types and constants for the parametrised interrupt
// controller.
//   state_e        FSM states of the presentation sequencer
//   STATUS_ADDR    read-only status register address
//   EN_BIT/MODE_BIT  bit positions inside a per-source CFG register
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_e;

    localparam logic [7:0] STATUS_ADDR = 8'hFF;
    localparam int         EN_BIT      = 7;
    localparam int         MODE_BIT    = 6;

endpackage

// File: rtl/intr_prio_arbiter.sv
// intr_prio_arbiter: combinational priority pick over the pending vector.
//   pend_i      pending bit per source
//   prio_i      packed priority fields, source i at [i*PRIO_W +: PRIO_W]
//   win_id_o    index of the winning source (0 when none pending)
//   any_pend_o  at least one source pending
module intr_prio_arbiter #(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = $clog2(NUM_INTR)
) (
    input  logic [NUM_INTR-1:0]        pend_i,
    input  logic [NUM_INTR*PRIO_W-1:0] prio_i,
    output logic [PRIO_W-1:0]          win_id_o,
    output logic                       any_pend_o
);

    logic [PRIO_W-1:0] best_prio;

    // Scanning upward with a strict '>' keeps the lowest index on a tie.
    always_comb begin
        best_prio  = '0;
        win_id_o   = '0;
        any_pend_o = 1'b0;
        for (int i = 0; i < NUM_INTR; i++) begin
            if (pend_i[i] && (!any_pend_o || prio_i[i*PRIO_W +: PRIO_W] > best_prio)) begin
                any_pend_o = 1'b1;
                best_prio  = prio_i[i*PRIO_W +: PRIO_W];
                win_id_o   = PRIO_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl_param.sv
// intr_ctrl_param: interrupt controller with NUM_INTR sources, per-source
// priority/enable/mode registers on an APB-style slave port, and a
// present-until-serviced handshake to the processor.
//   pclk_i, prstn_i               clock, async active-low reset
//   paddr_i/pwdata_i/pwrite_i/penable_i, prdata_o/pready_o/pslverr_o  slave port
//   intr_active_i                 peripheral interrupt lines
//   intr_to_service_o/intr_valid_o  presented id and its valid flag
//   intr_serviced_i               processor finished the presented id
//
// state   | meaning
// IDLE    | nothing presented; latch winner as soon as anything is pending
// PRESENT | id_q presented and held until intr_serviced_i
// GAP     | one quiet cycle so a dropped level line settles
module intr_ctrl_param
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_INTR = 16,
    parameter int PRIO_W   = $clog2(NUM_INTR)  // derived, leave at default
) (
    input  logic                pclk_i,
    input  logic                prstn_i,
    input  logic [7:0]          paddr_i,
    input  logic [7:0]          pwdata_i,
    input  logic                pwrite_i,
    input  logic                penable_i,
    output logic [7:0]          prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic [NUM_INTR-1:0] intr_active_i,
    output logic [PRIO_W-1:0]   intr_to_service_o,
    output logic                intr_valid_o,
    input  logic                intr_serviced_i
);

    // Only enable, mode and the priority field are stored; other bits read 0.
    localparam logic [7:0] CFG_MASK = 8'hC0 | 8'((1 << PRIO_W) - 1);

    logic [7:0]                 cfg_q [NUM_INTR];
    logic                       pready_q, pslverr_q;
    logic [7:0]                 prdata_q;
    logic [NUM_INTR-1:0]        act_q, pend_q, pend_d;
    state_e                     state_q;
    logic [PRIO_W-1:0]          id_q;
    logic                       valid_q;
    logic [NUM_INTR*PRIO_W-1:0] prio_flat;
    logic [PRIO_W-1:0]          win_id;
    logic                       any_pend;
    logic                       acc_start, acc_commit, addr_is_cfg, wr_cfg, svc_clr;
    logic [7:0]                 rd_data;
    logic                       rd_err;

    assign acc_start   = penable_i & ~pready_q;
    assign acc_commit  = penable_i & pready_q;
    assign addr_is_cfg = 32'(paddr_i) < 32'(NUM_INTR);
    assign wr_cfg      = acc_commit & pwrite_i & addr_is_cfg;
    assign svc_clr     = (state_q == PRESENT) & intr_serviced_i;

    assign prdata_o          = prdata_q;
    assign pready_o          = pready_q;
    assign pslverr_o         = pslverr_q;
    assign intr_to_service_o = id_q;
    assign intr_valid_o      = valid_q;

    always_comb begin
        rd_data = 8'h00;
        rd_err  = 1'b0;
        if (paddr_i == STATUS_ADDR) begin
            if (pwrite_i) rd_err  = 1'b1;
            else          rd_data = {valid_q, 1'b0, 6'(id_q)};
        end else if (addr_is_cfg) begin
            if (!pwrite_i) begin
                for (int i = 0; i < NUM_INTR; i++) begin
                    if (paddr_i == 8'(i)) rd_data = cfg_q[i];
                end
            end
        end else begin
            rd_err = 1'b1;
        end
    end

    // Read data and error are captured on the edge that raises pready_o.
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
            for (int i = 0; i < NUM_INTR; i++) cfg_q[i] <= 8'h80 | 8'(i);
        end else begin
            pready_q  <= acc_start;
            prdata_q  <= acc_start ? rd_data : 8'h00;
            pslverr_q <= acc_start ? rd_err : 1'b0;
            if (wr_cfg) begin
                for (int i = 0; i < NUM_INTR; i++) begin
                    if (paddr_i == 8'(i)) cfg_q[i] <= pwdata_i & CFG_MASK;
                end
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_INTR; i++) begin
            prio_flat[i*PRIO_W +: PRIO_W] = cfg_q[i][PRIO_W-1:0];
            if (!cfg_q[i][MODE_BIT]) begin
                pend_d[i] = intr_active_i[i] & cfg_q[i][EN_BIT];
            end else begin
                // A fresh rising edge outranks a service clear on the same
                // edge; disabling the source outranks both.
                if (svc_clr && id_q == PRIO_W'(i)) pend_d[i] = 1'b0;
                if (cfg_q[i][EN_BIT] && intr_active_i[i] && !act_q[i]) pend_d[i] = 1'b1;
                if (wr_cfg && paddr_i == 8'(i) && !pwdata_i[EN_BIT]) pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            act_q  <= '0;
            pend_q <= '0;
        end else begin
            act_q  <= intr_active_i;
            pend_q <= pend_d;
        end
    end

    intr_prio_arbiter #(
        .NUM_INTR (NUM_INTR),
        .PRIO_W   (PRIO_W)
    ) u_arb (
        .pend_i     (pend_q),
        .prio_i     (prio_flat),
        .win_id_o   (win_id),
        .any_pend_o (any_pend)
    );

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_pend) begin
                        id_q    <= win_id;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (intr_serviced_i) begin
                        valid_q <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl_param.sv
module tb_intr_ctrl_param;

    localparam int NUM_INTR = 16;
    localparam int PRIO_W   = 4;

    logic                pclk = 1'b0;
    logic                prstn = 1'b0;
    logic [7:0]          paddr = 8'h00;
    logic [7:0]          pwdata = 8'h00;
    logic                pwrite = 1'b0;
    logic                penable = 1'b0;
    logic [7:0]          prdata;
    logic                pready;
    logic                pslverr;
    logic [NUM_INTR-1:0] intr_active = '0;
    logic [PRIO_W-1:0]   intr_id;
    logic                intr_valid;
    logic                intr_serviced = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    intr_ctrl_param #(.NUM_INTR(NUM_INTR)) dut (
        .pclk_i            (pclk),
        .prstn_i           (prstn),
        .paddr_i           (paddr),
        .pwdata_i          (pwdata),
        .pwrite_i          (pwrite),
        .penable_i         (penable),
        .prdata_o          (prdata),
        .pready_o          (pready),
        .pslverr_o         (pslverr),
        .intr_active_i     (intr_active),
        .intr_to_service_o (intr_id),
        .intr_valid_o      (intr_valid),
        .intr_serviced_i   (intr_serviced)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic [7:0] a, input logic wr, input logic [7:0] wd,
                            output logic [7:0] rd, output logic err);
        int n;
        @(negedge pclk);
        paddr = a; pwrite = wr; pwdata = wd; penable = 1'b1;
        n = 0;
        do begin
            @(posedge pclk); #1;
            n++;
        end while (!pready && n < 8);
        if (!pready) chk("apb_timeout", 32'd0, 32'd1);
        rd  = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] rd;
        logic       err;
        apb_xfer(a, 1'b1, wd, rd, err);
        chk("wr_err", 32'(err), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!intr_valid && n < 60) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!intr_valid) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic service();
        @(negedge pclk);
        intr_serviced = 1'b1;
        @(posedge pclk); #1;
        chk("svc_drop", 32'(intr_valid), 32'd0);
        intr_serviced = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         seen;

        #12;
        chk("rst_valid", 32'(intr_valid), 32'd0);
        chk("rst_id", 32'(intr_id), 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", 32'(prdata), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        @(negedge pclk);
        prstn = 1'b1;

        for (int i = 0; i < NUM_INTR; i++) begin
            apb_xfer(8'(i), 1'b0, 8'h00, rd, err);
            chk($sformatf("rst_cfg%0d", i), 32'(rd), 32'h80 | 32'(i));
        end
        apb_xfer(8'h20, 1'b0, 8'h00, rd, err);
        chk("bad_addr_err", 32'(err), 32'd1);
        chk("bad_addr_data", 32'(rd), 32'd0);
        apb_xfer(8'hFF, 1'b1, 8'h55, rd, err);
        chk("status_wr_err", 32'(err), 32'd1);
        apb_xfer(8'hFF, 1'b0, 8'h00, rd, err);
        chk("status_idle", 32'(rd), 32'h00);
        chk("status_rd_err", 32'(err), 32'd0);

        for (int i = 0; i < NUM_INTR; i++) apb_wr(8'(i), 8'h80 | 8'(15 - i));
        apb_xfer(8'h03, 1'b0, 8'h00, rd, err);
        chk("rev_cfg3", 32'(rd), 32'h8C);

        // Reversed priorities: 0 (15) beats 4 (11) beats 7 (8).
        @(negedge pclk);
        intr_active = 16'h0091;
        wait_valid("rev_to0");
        chk("rev_id0", 32'(intr_id), 32'd0);
        intr_active[0] = 1'b0;
        service();
        wait_valid("rev_to4");
        chk("rev_id4", 32'(intr_id), 32'd4);
        apb_xfer(8'hFF, 1'b0, 8'h00, rd, err);
        chk("status_present", 32'(rd), 32'h84);
        intr_active[4] = 1'b0;
        service();
        wait_valid("rev_to7");
        chk("rev_id7", 32'(intr_id), 32'd7);
        intr_active[7] = 1'b0;
        service();
        repeat (4) @(posedge pclk);
        #1;
        chk("rev_quiet", 32'(intr_valid), 32'd0);

        // Equal priority 5 on sources 3 and 9: lowest index first.
        apb_wr(8'h03, 8'h85);
        apb_wr(8'h09, 8'h85);
        @(negedge pclk);
        intr_active[3] = 1'b1;
        intr_active[9] = 1'b1;
        wait_valid("tie_to3");
        chk("tie_id3", 32'(intr_id), 32'd3);
        intr_active[3] = 1'b0;
        service();
        wait_valid("tie_to9");
        chk("tie_id9", 32'(intr_id), 32'd9);
        // Leave line 9 high: it must come back exactly two edges after service.
        service();
        @(posedge pclk); #1;
        chk("gap_valid", 32'(intr_valid), 32'd0);
        @(posedge pclk); #1;
        chk("represent_valid", 32'(intr_valid), 32'd1);
        chk("represent_id", 32'(intr_id), 32'd9);
        intr_active[9] = 1'b0;
        service();
        repeat (4) @(posedge pclk);
        #1;
        chk("tie_quiet", 32'(intr_valid), 32'd0);

        // Edge mode on source 2, single-cycle pulse.
        apb_wr(8'h02, 8'hCD);
        @(negedge pclk);
        intr_active[2] = 1'b1;
        @(posedge pclk); #1;
        chk("edge_t0_valid", 32'(intr_valid), 32'd0);
        @(negedge pclk);
        intr_active[2] = 1'b0;
        @(posedge pclk); #1;
        chk("edge_t1_valid", 32'(intr_valid), 32'd1);
        chk("edge_t1_id", 32'(intr_id), 32'd2);
        repeat (5) @(posedge pclk);
        #1;
        chk("edge_hold", 32'(intr_valid), 32'd1);
        service();
        repeat (5) @(posedge pclk);
        #1;
        chk("edge_cleared", 32'(intr_valid), 32'd0);

        // Disabled level source stays silent, then fires once enabled.
        apb_wr(8'h05, 8'h05);
        @(negedge pclk);
        intr_active[5] = 1'b1;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge pclk); #1;
            if (intr_valid) seen++;
        end
        chk("dis_quiet", 32'(seen), 32'd0);
        apb_wr(8'h05, 8'h85);
        wait_valid("en_to5");
        chk("en_id5", 32'(intr_id), 32'd5);

        // Async reset while presenting and with pready_o high.
        @(negedge pclk);
        paddr = 8'h01; pwrite = 1'b0; penable = 1'b1;
        @(posedge pclk); #1;
        chk("pre_rst_pready", 32'(pready), 32'd1);
        #2;
        prstn = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(intr_valid), 32'd0);
        chk("rst_mid_pready", 32'(pready), 32'd0);
        chk("rst_mid_id", 32'(intr_id), 32'd0);
        penable = 1'b0;
        intr_active = '0;
        @(negedge pclk);
        prstn = 1'b1;
        apb_xfer(8'h05, 1'b0, 8'h00, rd, err);
        chk("post_rst_cfg5", 32'(rd), 32'h85);
        apb_xfer(8'h02, 1'b0, 8'h00, rd, err);
        chk("post_rst_cfg2", 32'(rd), 32'h82);
        apb_xfer(8'h03, 1'b0, 8'h00, rd, err);
        chk("post_rst_cfg3", 32'(rd), 32'h83);
        apb_xfer(8'h0F, 1'b0, 8'h00, rd, err);
        chk("post_rst_cfg15", 32'(rd), 32'h8F);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/intr_ctrl_param.md
# intr_ctrl_param

Parametrised successor to the 16-source APB interrupt controller. It accepts NUM_INTR peripheral interrupt lines and holds a programmable priority, enable bit and level/edge mode per source, all written over the APB-style slave port. It presents one winning interrupt at a time to the processor and holds it until the processor acknowledges service. It sits between the peripheral interrupt lines and the processor's interrupt/acknowledge pins.

## Interface
- NUM_INTR, 16: number of interrupt sources, 2..64.
- PRIO_W, $clog2(NUM_INTR): width of a priority field and of the interrupt id. Derived; do not override.
- pclk_i  in  1  single clock; all logic on rising edge.
- prstn_i  in  1  reset, asynchronous, active-low.
- paddr_i  in  8  register address.
- pwdata_i  in  8  write data.
- pwrite_i  in  1  1 = write, 0 = read.
- penable_i  in  1  access phase strobe.
- prdata_o  out  8  read data, valid while pready_o=1.
- pready_o  out  1  transfer-complete pulse.
- pslverr_o  out  1  error, valid while pready_o=1.
- intr_active_i  in  NUM_INTR  peripheral interrupt lines, synchronous to pclk_i.
- intr_to_service_o  out  PRIO_W  id of the interrupt being presented.
- intr_valid_o  out  1  intr_to_service_o is valid.
- intr_serviced_i  in  1  processor has finished servicing the presented id.

## Operation
- Register map, one 8-bit register CFG[i] per source at address i (i < NUM_INTR):
  - bits [PRIO_W-1:0]: priority. Higher value wins.
  - bit 6: mode. 0 = level, 1 = rising edge.
  - bit 7: enable.
  - Bits not listed read 0.
- Address 0xFF, STATUS, read-only: bit 7 = intr_valid_o; bits [5:0] = intr_to_service_o, zero-extended.
- Any other address, or a write to 0xFF: pslverr_o=1 with pready_o. Writes are dropped; reads return 0.
- Reset value of CFG[i]: priority = i, enable = 1, mode = level. This matches the previous generation's power-on map.
- Pending register pend_q[i], updated every edge:
  - Level mode: pend_q[i] = intr_active_i[i] & en[i].
  - Edge mode: set on a 0→1 transition of intr_active_i[i] (compared against a registered copy) when en[i]=1. Cleared only by service of id i, or by writing CFG[i] with enable=0.
- Arbitration: among set pend_q bits, the highest priority wins. Priorities need not be unique; on a tie the lowest index wins.
- FSM:
  - IDLE: when any pend_q bit is set, latch the winner into id_q and go to PRESENT.
  - PRESENT: intr_valid_o=1 and intr_to_service_o=id_q, held stable. No preemption: a higher-priority arrival waits. When intr_serviced_i is sampled 1, clear pend_q[id_q] if that source is edge-mode, then go to GAP.
  - GAP: one cycle with valid=0 so that a dropped level line settles. Then go to IDLE.
- Reprogramming CFG while in PRESENT does not change id_q.

## Timing
- All outputs reset to 0, and the FSM resets to IDLE. Reset asserted mid-transfer or mid-service clears everything immediately (asynchronous).
- APB transfer:
  - pready_o <= penable_i & ~pready_o, so it pulses for 1 cycle per transfer, one wait state.
  - A write commits at the edge where penable_i=1 and pready_o=1.
  - The master drops penable_i after seeing pready_o. If penable_i is held, pready_o pulses every other cycle.
- Interrupt latency: input high before edge t sets pend_q at t; intr_valid_o=1 after edge t+1.
- Service turnaround: intr_serviced_i sampled at edge s drops intr_valid_o after s. The next winner can be presented after edge s+2 at the earliest.
- intr_serviced_i outside PRESENT is ignored.
- A level source still high at the end of GAP is serviced again; this is required behaviour.

## Structure
- Package intr_ctrl_pkg holds:
  - FSM state enum: IDLE, PRESENT, GAP.
  - STATUS_ADDR = 8'hFF.
  - CFG bit positions: EN_BIT = 7, MODE_BIT = 6.
- Sub-module intr_prio_arbiter: combinational. Takes the pending vector and the priority array; returns the winning id and any_pending. Tie-break is lowest index.

## Test plan
- Reset-value scan: read all CFG[i] → 0x80|i for i < 16. Read 0x20 with NUM_INTR=16 → pslverr_o=1, prdata_o=0.
- Reversed priorities (CFG[i]=0x80|(15-i)), intr_active_i=16'h0091 → ids serviced in order 0, 4, 7. Each source is dropped before intr_serviced_i.
- Ties: CFG[3] and CFG[9] both priority 5, both lines active → id 3 first, then 9.
- Edge mode on source 2: a 1-cycle pulse on line 2 → intr_valid_o with id 2 two edges later. The pending bit survives the line dropping and clears only on intr_serviced_i.
- Disable: CFG[5]=0x05 (enable=0), line 5 high → intr_valid_o stays 0 for 50 cycles. Re-enabling → id 5 presented.
- Reset mid-PRESENT: deassert prstn_i while intr_valid_o=1 → valid=0 and pready_o=0 at once. After release, CFG values are back to reset values.
